// File: rtl/avmm_arbiter_2m.sv
// Two-master to one-slave Avalon-MM arbiter with round-robin grant and
// in-order read-response routing through a small tag FIFO.
module avmm_arbiter_2m #(
  parameter int ADDR_W   = 25,
  parameter int DATA_W   = 16,
  parameter int MAX_PEND = 4
) (
  input  logic                               Clk,
  input  logic                               Reset,
  input  logic [ADDR_W-1:0]                  m0_address,
  input  logic                               m0_read,
  input  logic                               m0_write,
  input  logic [DATA_W-1:0]                  m0_writedata,
  input  logic [DATA_W/8-1:0]                m0_byteenable,
  output logic                               m0_waitrequest,
  output logic                               m0_readdatavalid,
  input  logic [ADDR_W-1:0]                  m1_address,
  input  logic                               m1_read,
  input  logic                               m1_write,
  input  logic [DATA_W-1:0]                  m1_writedata,
  input  logic [DATA_W/8-1:0]                m1_byteenable,
  output logic                               m1_waitrequest,
  output logic                               m1_readdatavalid,
  output logic [DATA_W-1:0]                  m_readdata,
  output logic [ADDR_W-1:0]                  s_address,
  output logic                               s_read,
  output logic                               s_write,
  output logic [DATA_W-1:0]                  s_writedata,
  output logic [DATA_W/8-1:0]                s_byteenable,
  input  logic                               s_waitrequest,
  input  logic [DATA_W-1:0]                  s_readdata,
  input  logic                               s_readdatavalid,
  output logic [$clog2(MAX_PEND+1)-1:0]      pend_count,
  output logic                               err_rdv
);

  localparam int CNT_W = $clog2(MAX_PEND+1);
  localparam int PTR_W = (MAX_PEND > 1) ? $clog2(MAX_PEND) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_0 = 2'd1,
    BUSY_1 = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                rr_q, rr_d;
  logic [MAX_PEND-1:0] tag_q;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;

  logic full_s, empty_s;
  logic elig0_s, elig1_s;
  logic push_s, push_tag_s, pop_s, head_tag_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(MAX_PEND - 1)) begin
      return '0;
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  assign full_s  = (cnt_q == CNT_W'(MAX_PEND));
  assign empty_s = (cnt_q == '0);
  // Reads are held off while the tag FIFO is full; writes never are.
  assign elig0_s = m0_write | (m0_read & ~full_s);
  assign elig1_s = m1_write | (m1_read & ~full_s);

  assign pop_s      = s_readdatavalid & ~empty_s;
  assign head_tag_s = tag_q[rd_ptr_q];

  assign m0_readdatavalid = pop_s & ~head_tag_s;
  assign m1_readdatavalid = pop_s &  head_tag_s;
  assign m_readdata       = s_readdata;
  assign pend_count       = cnt_q;
  assign err_rdv          = err_q;

  // Arbitration FSM next state and slave-side command mux
  always_comb begin
    state_d        = state_q;
    rr_d           = rr_q;
    push_s         = 1'b0;
    push_tag_s     = 1'b0;
    s_address      = '0;
    s_read         = 1'b0;
    s_write        = 1'b0;
    s_writedata    = '0;
    s_byteenable   = '0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    case (state_q)
      IDLE: begin
        if (elig0_s && elig1_s) begin
          state_d = rr_q ? BUSY_1 : BUSY_0;
        end else if (elig0_s) begin
          state_d = BUSY_0;
        end else if (elig1_s) begin
          state_d = BUSY_1;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY_0: begin
        s_address      = m0_address;
        s_read         = m0_read;
        s_write        = m0_write;
        s_writedata    = m0_writedata;
        s_byteenable   = m0_byteenable;
        m0_waitrequest = s_waitrequest;
        if (!s_waitrequest) begin
          state_d    = IDLE;
          rr_d       = 1'b1;
          push_s     = m0_read;
          push_tag_s = 1'b0;
        end else begin
          state_d = BUSY_0;
        end
      end
      BUSY_1: begin
        s_address      = m1_address;
        s_read         = m1_read;
        s_write        = m1_write;
        s_writedata    = m1_writedata;
        s_byteenable   = m1_byteenable;
        m1_waitrequest = s_waitrequest;
        if (!s_waitrequest) begin
          state_d    = IDLE;
          rr_d       = 1'b0;
          push_s     = m1_read;
          push_tag_s = 1'b1;
        end else begin
          state_d = BUSY_1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Tag FIFO pointers, occupancy and sticky error next state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    err_d    = err_q | (s_readdatavalid & empty_s);
    if (push_s) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // State, pointer and tag storage registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      rr_q     <= 1'b0;
      tag_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      if (push_s) begin
        tag_q[wr_ptr_q] <= push_tag_s;
      end
    end
  end

endmodule

// File: tb/tb_avmm_arbiter_2m.sv
// Directed self-checking bench for avmm_arbiter_2m (default parameters).
module tb_avmm_arbiter_2m;

  logic        Clk;
  logic        Reset;
  logic [24:0] m0_address, m1_address, s_address;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [15:0] m0_writedata, m1_writedata, s_writedata;
  logic [1:0]  m0_byteenable, m1_byteenable, s_byteenable;
  logic        m0_waitrequest, m1_waitrequest;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [15:0] m_readdata, s_readdata;
  logic        s_read, s_write, s_waitrequest, s_readdatavalid;
  logic [2:0]  pend_count;
  logic        err_rdv;

  int checks   = 0;
  int failures = 0;

  avmm_arbiter_2m #(.ADDR_W(25), .DATA_W(16), .MAX_PEND(4)) dut (
    .Clk(Clk), .Reset(Reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_waitrequest(m0_waitrequest), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_waitrequest(m1_waitrequest), .m1_readdatavalid(m1_readdatavalid),
    .m_readdata(m_readdata),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
    .s_readdatavalid(s_readdatavalid),
    .pend_count(pend_count), .err_rdv(err_rdv)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    m0_address = '0; m0_read = 1'b0; m0_write = 1'b0; m0_writedata = '0; m0_byteenable = 2'b11;
    m1_address = '0; m1_read = 1'b0; m1_write = 1'b0; m1_writedata = '0; m1_byteenable = 2'b11;
    s_waitrequest = 1'b0; s_readdata = '0; s_readdatavalid = 1'b0;
    tick();
    tick();
    Reset = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    #1;
    chk("rst_m0_wait", m0_waitrequest, 1);
    chk("rst_m1_wait", m1_waitrequest, 1);
    chk("rst_m0_rdv", m0_readdatavalid, 0);
    chk("rst_m1_rdv", m1_readdatavalid, 0);
    chk("rst_s_read", s_read, 0);
    chk("rst_s_write", s_write, 0);
    chk("rst_pend", pend_count, 0);
    chk("rst_err", err_rdv, 0);

    // Single master write
    tick();
    m0_write = 1'b1; m0_address = 25'h10; m0_writedata = 16'hBEEF;
    #1;
    chk("w_idle_s_write", s_write, 0);
    chk("w_idle_m0_wait", m0_waitrequest, 1);
    tick();
    #1;
    chk("w_busy_s_write", s_write, 1);
    chk("w_busy_addr", s_address, 32'h10);
    chk("w_busy_data", s_writedata, 32'hBEEF);
    chk("w_busy_m0_wait", m0_waitrequest, 0);
    chk("w_busy_m1_wait", m1_waitrequest, 1);
    tick();
    m0_write = 1'b0;
    #1;
    chk("w_done_s_write", s_write, 0);
    chk("w_done_m0_wait", m0_waitrequest, 1);

    // Round-robin with both masters writing continuously
    do_reset();
    tick();
    m0_write = 1'b1; m0_address = 25'h100;
    m1_write = 1'b1; m1_address = 25'h200;
    #1;
    chk("rr_c0_s_write", s_write, 0);
    for (int i = 1; i <= 8; i++) begin
      tick();
      #1;
      chk("rr_s_write", s_write, (i % 2 == 1) ? 1 : 0);
      chk("rr_m0_wait", m0_waitrequest, (i % 4 == 1) ? 0 : 1);
      chk("rr_m1_wait", m1_waitrequest, (i % 4 == 3) ? 0 : 1);
      if (i % 2 == 1) begin
        chk("rr_addr", s_address, (i % 4 == 1) ? 32'h100 : 32'h200);
      end
    end
    tick();
    m0_write = 1'b0; m1_write = 1'b0;

    // Read routing: m0 reads A, m1 reads B, responses after 3 and 5 cycles
    do_reset();
    tick();
    m0_read = 1'b1; m0_address = 25'hA;
    m1_read = 1'b1; m1_address = 25'hB;
    #1;
    chk("rd_t0_s_read", s_read, 0);
    tick(); #1;
    chk("rd_t1_s_read", s_read, 1);
    chk("rd_t1_addr", s_address, 32'hA);
    chk("rd_t1_m0_wait", m0_waitrequest, 0);
    chk("rd_t1_m1_wait", m1_waitrequest, 1);
    tick(); m0_read = 1'b0; #1;
    chk("rd_t2_pend", pend_count, 1);
    chk("rd_t2_s_read", s_read, 0);
    tick(); #1;
    chk("rd_t3_addr", s_address, 32'hB);
    chk("rd_t3_m1_wait", m1_waitrequest, 0);
    chk("rd_t3_m0_wait", m0_waitrequest, 1);
    tick(); m1_read = 1'b0; s_readdatavalid = 1'b1; s_readdata = 16'h00D1; #1;
    chk("rd_t4_m0_rdv", m0_readdatavalid, 1);
    chk("rd_t4_m1_rdv", m1_readdatavalid, 0);
    chk("rd_t4_data", m_readdata, 32'hD1);
    chk("rd_t4_pend", pend_count, 2);
    tick(); s_readdatavalid = 1'b0; #1;
    chk("rd_t5_pend", pend_count, 1);
    chk("rd_t5_m0_rdv", m0_readdatavalid, 0);
    tick();
    tick();
    tick(); s_readdatavalid = 1'b1; s_readdata = 16'h00D2; #1;
    chk("rd_t8_m1_rdv", m1_readdatavalid, 1);
    chk("rd_t8_m0_rdv", m0_readdatavalid, 0);
    chk("rd_t8_data", m_readdata, 32'hD2);
    tick(); s_readdatavalid = 1'b0; #1;
    chk("rd_t9_pend", pend_count, 0);

    // Full FIFO: four m0 reads with no responses
    do_reset();
    tick();
    m0_read = 1'b1; m0_address = 25'h40;
    #1;
    for (int i = 1; i <= 7; i++) begin
      tick(); #1;
      chk("full_pend", pend_count, i / 2);
      chk("full_s_read", s_read, (i % 2 == 1) ? 1 : 0);
      chk("full_m0_wait", m0_waitrequest, (i % 2 == 1) ? 0 : 1);
    end
    tick(); m1_write = 1'b1; m1_address = 25'h50; m1_writedata = 16'h1234; #1;
    chk("full_t8_pend", pend_count, 4);
    chk("full_t8_s_read", s_read, 0);
    tick(); #1;
    chk("full_t9_s_write", s_write, 1);
    chk("full_t9_s_read", s_read, 0);
    chk("full_t9_addr", s_address, 32'h50);
    chk("full_t9_m1_wait", m1_waitrequest, 0);
    chk("full_t9_m0_wait", m0_waitrequest, 1);
    tick(); m1_write = 1'b0; #1;
    chk("full_t10_s_read", s_read, 0);
    tick(); s_readdatavalid = 1'b1; s_readdata = 16'h0007; #1;
    chk("full_t11_s_read", s_read, 0);
    chk("full_t11_m0_rdv", m0_readdatavalid, 1);
    tick(); s_readdatavalid = 1'b0; #1;
    chk("full_t12_pend", pend_count, 3);
    chk("full_t12_s_read", s_read, 0);
    tick(); #1;
    chk("full_t13_s_read", s_read, 1);
    chk("full_t13_m0_wait", m0_waitrequest, 0);
    tick(); m0_read = 1'b0; s_readdatavalid = 1'b1; #1;
    chk("full_t14_pend", pend_count, 4);
    chk("full_t14_m0_rdv", m0_readdatavalid, 1);

    // Waitrequest stall in BUSY_1, then accept together with a response
    tick(); s_readdatavalid = 1'b0; m1_read = 1'b1; m1_address = 25'h33; s_waitrequest = 1'b1; #1;
    chk("stall_pend", pend_count, 3);
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      chk("stall_s_read", s_read, 1);
      chk("stall_addr", s_address, 32'h33);
      chk("stall_m1_wait", m1_waitrequest, 1);
      chk("stall_m0_wait", m0_waitrequest, 1);
    end
    tick(); s_waitrequest = 1'b0; s_readdatavalid = 1'b1; #1;
    chk("pp_m1_wait", m1_waitrequest, 0);
    chk("pp_m0_rdv", m0_readdatavalid, 1);
    chk("pp_pend_before", pend_count, 3);
    tick(); m1_read = 1'b0; s_readdatavalid = 1'b0; #1;
    chk("pp_pend_after", pend_count, 3);
    chk("pp_s_read", s_read, 0);

    // Unexpected response, then reset while busy with two reads pending
    do_reset();
    tick(); s_readdatavalid = 1'b1; #1;
    chk("err_m0_rdv", m0_readdatavalid, 0);
    chk("err_m1_rdv", m1_readdatavalid, 0);
    chk("err_before", err_rdv, 0);
    tick(); s_readdatavalid = 1'b0; m0_read = 1'b1; m0_address = 25'h60; #1;
    chk("err_set", err_rdv, 1);
    tick(); #1;
    chk("err_t2_s_read", s_read, 1);
    tick(); #1;
    chk("err_t3_pend", pend_count, 1);
    tick();
    tick(); s_waitrequest = 1'b1; #1;
    chk("err_t5_pend", pend_count, 2);
    tick(); #1;
    chk("err_t6_s_read", s_read, 1);
    chk("err_t6_m0_wait", m0_waitrequest, 1);
    chk("err_t6_held", err_rdv, 1);
    chk("err_t6_pend", pend_count, 2);
    Reset = 1'b1;
    tick(); Reset = 1'b0; m0_read = 1'b0; s_waitrequest = 1'b0; #1;
    chk("rst2_s_read", s_read, 0);
    chk("rst2_pend", pend_count, 0);
    chk("rst2_err", err_rdv, 0);
    chk("rst2_m0_wait", m0_waitrequest, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
